// File: rtl/char_tx_queue.sv
// char_tx_queue: byte FIFO feeding a UART transmitter (8N1, LSB first).
//
// Bytes strobed in on `start` are buffered in a 2**DEPTH_LOG2-entry FIFO and
// serialised onto `out` one frame at a time. Consecutive frames are separated
// by exactly one idle cycle after the stop bit.
//
// Build option: define CHAR_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (8E1, 11 bit periods per frame).
//
// Parameters:
//   CLKS_PER_BIT  sysclk cycles per serial bit (2..16383)
//   DEPTH_LOG2    log2 of FIFO depth
//
// Ports:
//   sysclk    in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   data      in   [7:0] byte to enqueue, sampled when start=1
//   start     in   one-cycle write strobe
//   out       out  serial TX line, idle high (registered)
//   pulse     out  strobe on the last counter cycle of each bit period
//   busy      out  FIFO non-empty or frame in progress (registered)
//   full      out  FIFO holds 2**DEPTH_LOG2 entries (registered)
//   overflow  out  sticky: a write was dropped because the FIFO was full
module char_tx_queue #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       out,
    output logic       pulse,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CntW-1:0]       CntLast   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]       CntOne    = CntW'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CountOne  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CountFull = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q, state_d;

    // FIFO
    logic [7:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push, pop;

    // Transmitter datapath
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            bit_end;
    logic            out_d;

    logic out_q, busy_q, full_q, overflow_q;

`ifdef CHAR_TX_PARITY_EN
    logic parity_q;
`endif

    assign bit_end = (cnt_q == CntLast);

    // The FSM only pops from IDLE with data present, so a pop never underflows.
    // A pop frees a slot in the same cycle, so a write while full is accepted then.
    assign pop  = (state_q == StIdle) && (count_q != '0);
    assign push = start && (!full_q || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    // FSM: state register
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (count_q != '0) state_d = StStart;
            StStart:  if (bit_end) state_d = StData;
            StData: begin
                if (bit_end && (bit_idx_q == 3'd7)) begin
`ifdef CHAR_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
            StParity: if (bit_end) state_d = StStop;
            StStop:   if (bit_end) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs (line level is registered into out_q below)
    always_comb begin
        out_d = 1'b1;
        pulse = 1'b0;
        case (state_q)
            StIdle:   out_d = 1'b1;
            StStart:  out_d = 1'b0;
            StData:   out_d = shift_q[0];
`ifdef CHAR_TX_PARITY_EN
            StParity: out_d = parity_q;
`else
            StParity: out_d = 1'b1;
`endif
            StStop:   out_d = 1'b1;
            default:  out_d = 1'b1;
        endcase
        if (state_q != StIdle) begin
            pulse = bit_end;
        end
    end

    // FIFO storage needs no reset: pointers and count define validity.
    always_ff @(posedge sysclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            out_q      <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q <= count_d;
            // Flags computed from next-state values so they line up with count_q.
            full_q  <= (count_d == CountFull);
            busy_q  <= (state_d != StIdle) || (count_d != '0);
            if (start && !push) overflow_q <= 1'b1;
            out_q <= out_d;

            if (pop) begin
                shift_q   <= mem_q[rd_ptr_q];
                cnt_q     <= '0;
                bit_idx_q <= '0;
            end else if (state_q != StIdle) begin
                if (bit_end) begin
                    cnt_q <= '0;
                    if (state_q == StData) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_q <= cnt_q + CntOne;
                end
            end
        end
    end

`ifdef CHAR_TX_PARITY_EN
    always_ff @(posedge sysclk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^mem_q[rd_ptr_q];
        end
    end
`endif

    assign out      = out_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_char_tx_queue.sv
// Bench for char_tx_queue. Expected line/flag behaviour is derived from a
// frame timeline: each accepted byte gets a pop edge, and every output at a
// given cycle follows from where that cycle falls relative to those edges.
module tb_char_tx_queue;

    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
`ifdef CHAR_TX_PARITY_EN
    localparam int BITS  = 11;
`else
    localparam int BITS  = 10;
`endif
    localparam int FRAME = BITS * CPB;

    logic       sysclk;
    logic       rst;
    logic [7:0] data;
    logic       start;
    logic       out;
    logic       pulse;
    logic       busy;
    logic       full;
    logic       overflow;

    char_tx_queue #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (DL2)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .data     (data),
        .start    (start),
        .out      (out),
        .pulse    (pulse),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int         pop;
        logic [7:0] b;
    } frame_t;

    frame_t fq[$];
    int     last_pop;
    bit     m_ovf;
    int     cyc;
    int     n_cmp;
    int     n_bad;
    int     pulse_cnt;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: apply the effect of clock edge t.
    function automatic void model_edge(input int t, input logic s, input logic [7:0] d,
                                       input logic r);
        int  occ;
        bit  pop_now;
        int  p;
        if (r) begin
            fq.delete();
            last_pop = -100000;
            m_ovf    = 1'b0;
            return;
        end
        while (fq.size() > 0 && t > fq[0].pop + FRAME + 2) void'(fq.pop_front());
        occ     = 0;
        pop_now = 1'b0;
        foreach (fq[i]) begin
            if (fq[i].pop >= t) occ++;
            if (fq[i].pop == t) pop_now = 1'b1;
        end
        if (s) begin
            if (occ < DEPTH || pop_now) begin
                // One idle cycle separates a frame end from the next pop.
                p = (t + 1 > last_pop + FRAME + 1) ? t + 1 : last_pop + FRAME + 1;
                fq.push_back('{pop: p, b: d});
                last_pop = p;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endfunction

    function automatic logic exp_out(input int c);
        int off;
        int k;
        foreach (fq[i]) begin
            off = c - fq[i].pop - 1;
            if (off >= 0 && off < FRAME) begin
                k = off / CPB;
                if (k == 0) return 1'b0;
                if (k <= 8) return fq[i].b[k-1];
                if (BITS == 11 && k == 9) return ^fq[i].b;
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_pulse(input int c);
        int off;
        foreach (fq[i]) begin
            off = c - fq[i].pop;
            if (off >= 0 && off < FRAME && (off % CPB) == CPB - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int occ_after(input int c);
        int n;
        n = 0;
        foreach (fq[i]) if (fq[i].pop > c) n++;
        return n;
    endfunction

    function automatic logic exp_busy(input int c);
        foreach (fq[i]) if (c - fq[i].pop >= 0 && c - fq[i].pop < FRAME) return 1'b1;
        return (occ_after(c) != 0);
    endfunction

    function automatic bit pop_at(input int t);
        foreach (fq[i]) if (fq[i].pop == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic s, input logic [7:0] d, input logic r);
        start = s;
        data  = d;
        rst   = r;
        @(posedge sysclk);
        cyc++;
        model_edge(cyc, s, d, r);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        if (pulse === 1'b1) pulse_cnt++;
        chk("out", out, exp_out(cyc));
        chk("pulse", pulse, exp_pulse(cyc));
        chk("busy", busy, exp_busy(cyc));
        chk("full", full, (occ_after(cyc) == DEPTH));
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_busy(cyc) && guard < 2000) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        step(1'b0, 8'h00, 1'b0);
        chk("drain_busy", busy, 1'b0);
    endtask

    initial begin
        int guard;
        int p;
        sysclk    = 1'b0;
        start     = 1'b0;
        data      = 8'h00;
        rst       = 1'b1;
        cyc       = 0;
        n_cmp     = 0;
        n_bad     = 0;
        pulse_cnt = 0;
        last_pop  = -100000;
        m_ovf     = 1'b0;

        // Reset state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Single byte
        pulse_cnt = 0;
        step(1'b1, 8'h41, 1'b0);
        drain();
        chk_int("single_pulses", pulse_cnt, BITS);

        // Burst of three
        step(1'b1, 8'h48, 1'b0);
        step(1'b1, 8'h49, 1'b0);
        step(1'b1, 8'h21, 1'b0);
        drain();
        chk("burst_ovf", overflow, 1'b0);

        // Fill FIFO, then write on the exact pop edge
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
        chk("fill_full", full, 1'b1);
        guard = 0;
        while (!pop_at(cyc + 1) && guard < 500) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        step(1'b1, 8'hA5, 1'b0);
        chk("fullpop_full", full, 1'b1);
        chk("fullpop_ovf", overflow, 1'b0);
        drain();

        // Reset during data bit 3
        step(1'b1, 8'h3C, 1'b0);
        p = last_pop;
        guard = 0;
        while (cyc < p + 4 * CPB + 1 && guard < 500) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        step(1'b0, 8'h00, 1'b1);
        chk("rst_out", out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        drain();

        // Overflow: six back-to-back writes into a four-entry FIFO
        for (int i = 0; i < 6; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
        chk("ovf_set", overflow, 1'b1);
        drain();
        chk("ovf_sticky", overflow, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Random traffic with rare resets
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 499) == 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
